// File: rtl/clk_src_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : clk_src_supervisor
//  Purpose  : Chooses between the primary and backup (AD9516-fed) MMCM clock,
//             qualifies and retries the backup lock, drives the glitch-free
//             clock-select, falls back to primary on lock loss and releases
//             the downstream active-low resets in timed stages.
//  Ports    : clk_i         supervisor clock (primary MMCM domain)
//             arst_i        asynchronous reset, active-high
//             pri_locked_i  primary MMCM locked (async, synchronised inside)
//             bak_locked_i  backup MMCM locked (async, synchronised inside)
//             force_pri_i   level, pin selection to the primary clock
//             rearm_i       single-cycle pulse, retry backup acquisition
//             mmcm_rst_o    backup MMCM reset request
//             sel_o         clock select, 0 = primary, 1 = backup
//             rst_n_o       staged active-low resets, bit 0 released first
//             fail_o        sticky backup-unusable flag
//             retry_cnt_o   backup MMCM resets issued since reset/rearm
//             state_o       WAIT_BAK=0 QUALIFY=1 MMCM_RST=2 SWITCH=3 RUN=4
//  Revision : 1.0  initial release
// ============================================================================
module clk_src_supervisor #(
    parameter int LOCK_TIMEOUT = 1000,
    parameter int LOCK_STABLE  = 256,
    parameter int RST_PULSE    = 16,
    parameter int MAX_RETRY    = 3,
    parameter int SWITCH_HOLD  = 64,
    parameter int STAGE_GAP    = 32,
    parameter int NUM_STAGES   = 4
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  pri_locked_i,
    input  logic                  bak_locked_i,
    input  logic                  force_pri_i,
    input  logic                  rearm_i,
    output logic                  mmcm_rst_o,
    output logic                  sel_o,
    output logic [NUM_STAGES-1:0] rst_n_o,
    output logic                  fail_o,
    output logic [3:0]            retry_cnt_o,
    output logic [2:0]            state_o
);

    localparam int c_ATT_W   = $clog2(LOCK_TIMEOUT + 1);
    localparam int c_STB_W   = $clog2(LOCK_STABLE + 1);
    localparam int c_PLS_W   = $clog2(RST_PULSE + 1);
    localparam int c_HLD_W   = $clog2(SWITCH_HOLD + 1);
    localparam int c_RUN_MAX = NUM_STAGES * STAGE_GAP;
    localparam int c_RUN_W   = $clog2(c_RUN_MAX + 1);

    localparam logic [c_ATT_W-1:0] c_ATT_LAST  = c_ATT_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_ATT_W-1:0] c_ATT_MAX   = c_ATT_W'(LOCK_TIMEOUT);
    localparam logic [c_ATT_W-1:0] c_ATT_ONE   = c_ATT_W'(1);
    localparam logic [c_STB_W-1:0] c_STB_LAST  = c_STB_W'(LOCK_STABLE - 1);
    localparam logic [c_STB_W-1:0] c_STB_ONE   = c_STB_W'(1);
    localparam logic [c_PLS_W-1:0] c_PLS_LAST  = c_PLS_W'(RST_PULSE - 1);
    localparam logic [c_PLS_W-1:0] c_PLS_ONE   = c_PLS_W'(1);
    localparam logic [c_HLD_W-1:0] c_HLD_LAST  = c_HLD_W'(SWITCH_HOLD - 1);
    localparam logic [c_HLD_W-1:0] c_HLD_ONE   = c_HLD_W'(1);
    localparam logic [c_RUN_W-1:0] c_RUN_TOP   = c_RUN_W'(c_RUN_MAX);
    localparam logic [c_RUN_W-1:0] c_RUN_ONE   = c_RUN_W'(1);
    localparam logic [3:0]         c_MAX_RETRY = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_WAIT_BAK = 3'd0,
        S_QUALIFY  = 3'd1,
        S_MMCM_RST = 3'd2,
        S_SWITCH   = 3'd3,
        S_RUN      = 3'd4
    } state_t;

    // Lock synchronisers
    logic r_pri_meta, r_pri_s, r_bak_meta, r_bak_s;

    state_t                r_state,   w_state_nxt;
    logic [c_ATT_W-1:0]    r_attempt, w_attempt_nxt;
    logic [c_STB_W-1:0]    r_stable,  w_stable_nxt;
    logic [c_PLS_W-1:0]    r_pulse,   w_pulse_nxt;
    logic [c_HLD_W-1:0]    r_hold,    w_hold_nxt;
    logic [c_RUN_W-1:0]    r_run,     w_run_nxt;
    logic [3:0]            r_retry,   w_retry_nxt;
    logic                  r_sel,     w_sel_nxt;
    logic                  r_fail,    w_fail_nxt;
    logic [NUM_STAGES-1:0] r_rst_n,   w_rst_n_nxt;
    logic                  r_mmcm_rst;

    logic [c_ATT_W-1:0]    w_attempt_inc;
    logic [c_RUN_W-1:0]    w_run_inc;
    logic [NUM_STAGES-1:0] w_stage_on;
    logic                  w_timeout;
    logic                  w_lock_tgt;

    assign w_attempt_inc = (r_attempt == c_ATT_MAX) ? r_attempt : r_attempt + c_ATT_ONE;
    assign w_run_inc     = (r_run == c_RUN_TOP) ? r_run : r_run + c_RUN_ONE;
    assign w_timeout     = (r_attempt == c_ATT_LAST);
    // sel_o doubles as the SWITCH target: it is loaded on SWITCH entry only
    assign w_lock_tgt    = r_sel ? r_bak_s : r_pri_s;

    // Stage k is released once the RUN counter reaches (k+1)*STAGE_GAP; the
    // comparison uses the incremented count so the register lands in step.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        assign w_stage_on[k] = (w_run_inc >= c_RUN_W'((k + 1) * STAGE_GAP));
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_pri_meta <= 1'b0;
            r_pri_s    <= 1'b0;
            r_bak_meta <= 1'b0;
            r_bak_s    <= 1'b0;
        end else begin
            r_pri_meta <= pri_locked_i;
            r_pri_s    <= r_pri_meta;
            r_bak_meta <= bak_locked_i;
            r_bak_s    <= r_bak_meta;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state    <= S_WAIT_BAK;
            r_attempt  <= '0;
            r_stable   <= '0;
            r_pulse    <= '0;
            r_hold     <= '0;
            r_run      <= '0;
            r_retry    <= '0;
            r_sel      <= 1'b0;
            r_fail     <= 1'b0;
            r_rst_n    <= '0;
            r_mmcm_rst <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_attempt  <= w_attempt_nxt;
            r_stable   <= w_stable_nxt;
            r_pulse    <= w_pulse_nxt;
            r_hold     <= w_hold_nxt;
            r_run      <= w_run_nxt;
            r_retry    <= w_retry_nxt;
            r_sel      <= w_sel_nxt;
            r_fail     <= w_fail_nxt;
            r_rst_n    <= w_rst_n_nxt;
            r_mmcm_rst <= (w_state_nxt == S_MMCM_RST);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_attempt_nxt = r_attempt;
        w_stable_nxt  = r_stable;
        w_pulse_nxt   = r_pulse;
        w_hold_nxt    = r_hold;
        w_run_nxt     = r_run;
        w_retry_nxt   = r_retry;
        w_sel_nxt     = r_sel;
        w_fail_nxt    = r_fail;
        w_rst_n_nxt   = '0;

        unique case (r_state)
            S_WAIT_BAK, S_QUALIFY: begin
                w_attempt_nxt = w_attempt_inc;
                if (force_pri_i) begin
                    w_state_nxt = S_SWITCH;
                    w_sel_nxt   = 1'b0;
                    w_hold_nxt  = '0;
                end else if (w_timeout) begin
                    if (r_retry < c_MAX_RETRY) begin
                        w_state_nxt   = S_MMCM_RST;
                        w_retry_nxt   = r_retry + 4'd1;
                        w_pulse_nxt   = '0;
                        w_attempt_nxt = '0;
                    end else begin
                        w_fail_nxt  = 1'b1;
                        w_state_nxt = S_SWITCH;
                        w_sel_nxt   = 1'b0;
                        w_hold_nxt  = '0;
                    end
                end else if (r_state == S_WAIT_BAK) begin
                    if (r_bak_s) begin
                        w_state_nxt  = S_QUALIFY;
                        w_stable_nxt = '0;
                    end
                end else begin
                    // QUALIFY: any low sample restarts qualification
                    if (!r_bak_s) begin
                        w_state_nxt = S_WAIT_BAK;
                    end else if (r_stable == c_STB_LAST) begin
                        w_state_nxt = S_SWITCH;
                        w_sel_nxt   = 1'b1;
                        w_hold_nxt  = '0;
                    end else begin
                        w_stable_nxt = r_stable + c_STB_ONE;
                    end
                end
            end

            S_MMCM_RST: begin
                if (force_pri_i) begin
                    w_state_nxt = S_SWITCH;
                    w_sel_nxt   = 1'b0;
                    w_hold_nxt  = '0;
                end else if (r_pulse == c_PLS_LAST) begin
                    w_state_nxt   = S_WAIT_BAK;
                    w_attempt_nxt = '0;
                end else begin
                    w_pulse_nxt = r_pulse + c_PLS_ONE;
                end
            end

            S_SWITCH: begin
                // Hold time only counts while the selected clock is locked
                if (!w_lock_tgt) begin
                    w_hold_nxt = '0;
                end else if (r_hold == c_HLD_LAST) begin
                    w_state_nxt = S_RUN;
                    w_run_nxt   = '0;
                end else begin
                    w_hold_nxt = r_hold + c_HLD_ONE;
                end
            end

            S_RUN: begin
                w_run_nxt   = w_run_inc;
                w_rst_n_nxt = w_stage_on;
                if (r_sel) begin
                    if (!r_bak_s) begin
                        w_fail_nxt  = 1'b1;
                        w_state_nxt = S_SWITCH;
                        w_sel_nxt   = 1'b0;
                        w_hold_nxt  = '0;
                        w_rst_n_nxt = '0;
                    end else if (force_pri_i) begin
                        w_state_nxt = S_SWITCH;
                        w_sel_nxt   = 1'b0;
                        w_hold_nxt  = '0;
                        w_rst_n_nxt = '0;
                    end
                end else begin
                    if (!r_pri_s) begin
                        w_state_nxt = S_SWITCH;
                        w_hold_nxt  = '0;
                        w_rst_n_nxt = '0;
                    end else if (rearm_i && !force_pri_i) begin
                        w_fail_nxt    = 1'b0;
                        w_retry_nxt   = '0;
                        w_attempt_nxt = '0;
                        w_state_nxt   = S_WAIT_BAK;
                        w_rst_n_nxt   = '0;
                    end
                end
            end

            default: begin
                w_state_nxt = S_WAIT_BAK;
            end
        endcase
    end

    assign mmcm_rst_o  = r_mmcm_rst;
    assign sel_o       = r_sel;
    assign rst_n_o     = r_rst_n;
    assign fail_o      = r_fail;
    assign retry_cnt_o = r_retry;
    assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_clk_src_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_src_supervisor
//  Purpose  : Self-checking bench for clk_src_supervisor with small timing
//             parameters; table-driven vectors plus directed sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clk_src_supervisor;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       pri = 1'b0;
    logic       bak = 1'b0;
    logic       frc = 1'b0;
    logic       rearm = 1'b0;
    logic       mmcm_rst;
    logic       sel;
    logic [2:0] rst_n;
    logic       fail;
    logic [3:0] retry;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    clk_src_supervisor #(
        .LOCK_TIMEOUT (20),
        .LOCK_STABLE  (8),
        .RST_PULSE    (4),
        .MAX_RETRY    (2),
        .SWITCH_HOLD  (6),
        .STAGE_GAP    (3),
        .NUM_STAGES   (3)
    ) dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .pri_locked_i (pri),
        .bak_locked_i (bak),
        .force_pri_i  (frc),
        .rearm_i      (rearm),
        .mmcm_rst_o   (mmcm_rst),
        .sel_o        (sel),
        .rst_n_o      (rst_n),
        .fail_o       (fail),
        .retry_cnt_o  (retry),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         pri;
        bit         bak;
        int         ticks;
        logic [2:0] st;
        bit         sel;
        logic [2:0] rstn;
        bit         fail;
        logic [3:0] retry;
        bit         mmcm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit p, bit b, int t, logic [2:0] s, bit sl,
                                logic [2:0] rn, bit f, logic [3:0] rc, bit m);
        vec_t v;
        v.rst = r; v.pri = p; v.bak = b; v.ticks = t; v.st = s; v.sel = sl;
        v.rstn = rn; v.fail = f; v.retry = rc; v.mmcm = m;
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic p, input logic b);
        arst  = 1'b1;
        pri   = p;
        bak   = b;
        frc   = 1'b0;
        rearm = 1'b0;
        @(posedge clk);
        #1;
        arst = 1'b0;
    endtask

    // Packed view {state, sel, rst_n, fail, retry, mmcm_rst}
    task automatic chk_all(input string name, input logic [2:0] s, input logic sl,
                           input logic [2:0] rn, input logic f, input logic [3:0] rc,
                           input logic m);
        logic [12:0] act, exp;
        act = {state, sel, rst_n, fail, retry, mmcm_rst};
        exp = {s, sl, rn, f, rc, m};
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: {state,sel,rst_n,fail,retry,mmcm} got %0d,%0d,%b,%0d,%0d,%0d want %0d,%0d,%b,%0d,%0d,%0d",
                     name, state, sel, rst_n, fail, retry, mmcm_rst, s, sl, rn, f, rc, m);
        end
    endtask

    task automatic chk_state(input string name, input logic [2:0] s);
        n_checks++;
        if (state !== s) begin
            n_errors++;
            $display("FAIL %s: state got %0d want %0d", name, state, s);
        end
    endtask

    initial begin
        // ---- Scenario 1: both locked from t0, backup qualifies ----
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 2, 0, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 7, 1, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 3, 1, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 5, 3, 1, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 4, 1, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 2, 4, 1, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 4, 1, 3'b001, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 2, 4, 1, 3'b001, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 4, 1, 3'b011, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 2, 4, 1, 3'b011, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 4, 1, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 5, 4, 1, 3'b111, 0, 0, 0));
        // ---- Scenario 2: backup never locks, two retries then give up ----
        vecs.push_back(mk(1, 1, 0, 0,  0, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 19, 0, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1,  2, 0, 3'b000, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 3,  2, 0, 3'b000, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1,  0, 0, 3'b000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 19, 0, 0, 3'b000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1,  2, 0, 3'b000, 0, 2, 1));
        vecs.push_back(mk(0, 1, 0, 3,  2, 0, 3'b000, 0, 2, 1));
        vecs.push_back(mk(0, 1, 0, 1,  0, 0, 3'b000, 0, 2, 0));
        vecs.push_back(mk(0, 1, 0, 19, 0, 0, 3'b000, 0, 2, 0));
        vecs.push_back(mk(0, 1, 0, 1,  3, 0, 3'b000, 1, 2, 0));
        vecs.push_back(mk(0, 1, 0, 6,  4, 0, 3'b000, 1, 2, 0));
        vecs.push_back(mk(0, 1, 0, 3,  4, 0, 3'b001, 1, 2, 0));
        vecs.push_back(mk(0, 1, 0, 3,  4, 0, 3'b011, 1, 2, 0));
        vecs.push_back(mk(0, 1, 0, 3,  4, 0, 3'b111, 1, 2, 0));

        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                do_reset(vecs[i].pri, vecs[i].bak);
            end else begin
                pri = vecs[i].pri;
                bak = vecs[i].bak;
            end
            tick(vecs[i].ticks);
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].sel, vecs[i].rstn,
                    vecs[i].fail, vecs[i].retry, vecs[i].mmcm);
        end

        // ---- Primary lock loss in RUN on primary: reset held until relock ----
        pri = 1'b0;
        tick(2); chk_all("pri_loss_pre", 4, 0, 3'b111, 1, 2, 0);
        tick(1); chk_all("pri_loss_sw", 3, 0, 3'b000, 1, 2, 0);
        pri = 1'b1;
        tick(7); chk_all("pri_relock_hold", 3, 0, 3'b000, 1, 2, 0);
        tick(1); chk_all("pri_relock_run", 4, 0, 3'b000, 1, 2, 0);
        tick(9); chk_all("pri_relock_rel", 4, 0, 3'b111, 1, 2, 0);

        // ---- Scenario 5: rearm ignored under force, honoured otherwise ----
        bak = 1'b1;
        frc = 1'b1;
        tick(3);
        rearm = 1'b1; tick(1); rearm = 1'b0;
        chk_all("rearm_forced", 4, 0, 3'b111, 1, 2, 0);
        frc = 1'b0;
        rearm = 1'b1; tick(1); rearm = 1'b0;
        chk_all("rearm_taken", 0, 0, 3'b000, 0, 0, 0);
        tick(1); chk_all("rearm_qual", 1, 0, 3'b000, 0, 0, 0);
        tick(8); chk_all("rearm_switch", 3, 1, 3'b000, 0, 0, 0);
        tick(6); chk_all("rearm_run", 4, 1, 3'b000, 0, 0, 0);
        tick(9); chk_all("rearm_rel", 4, 1, 3'b111, 0, 0, 0);

        // ---- Scenario 3: backup lost while running on it ----
        bak = 1'b0;
        tick(2); chk_all("bak_loss_pre", 4, 1, 3'b111, 0, 0, 0);
        tick(1); chk_all("bak_loss_sw", 3, 0, 3'b000, 1, 0, 0);
        tick(5); chk_all("bak_loss_hold", 3, 0, 3'b000, 1, 0, 0);
        tick(1); chk_all("bak_loss_run", 4, 0, 3'b000, 1, 0, 0);
        tick(3); chk_all("bak_loss_st0", 4, 0, 3'b001, 1, 0, 0);
        tick(6); chk_all("bak_loss_st2", 4, 0, 3'b111, 1, 0, 0);

        // ---- Scenario 4: backup lock toggling every 5 cycles never qualifies ----
        do_reset(1'b1, 1'b0);
        for (int c = 1; c <= 68; c++) begin
            bak = ((c / 5) % 2) == 1;
            tick(1);
            if (c == 19 || c == 43) begin
                n_checks++;
                if (state > 3'd1) begin
                    n_errors++;
                    $display("FAIL tog_pre%0d: state got %0d want 0 or 1", c, state);
                end
            end
            if (c == 20) chk_all("tog_to1", 2, 0, 3'b000, 0, 1, 1);
            if (c == 44) chk_all("tog_to2", 2, 0, 3'b000, 0, 2, 1);
            if (c == 67) begin
                n_checks++;
                if (state > 3'd1) begin
                    n_errors++;
                    $display("FAIL tog_pre67: state got %0d want 0 or 1", state);
                end
            end
            if (c == 68) chk_all("tog_giveup", 3, 0, 3'b000, 1, 2, 0);
        end

        // ---- Force to primary during MMCM reset pulse ----
        do_reset(1'b1, 1'b0);
        tick(21);
        chk_all("mr_pulse", 2, 0, 3'b000, 0, 1, 1);
        frc = 1'b1;
        tick(1);
        chk_all("mr_force", 3, 0, 3'b000, 0, 1, 0);
        frc = 1'b0;

        // ---- Scenario 6: async reset mid MMCM reset pulse ----
        do_reset(1'b1, 1'b0);
        tick(21);
        chk_all("ar_pre", 2, 0, 3'b000, 0, 1, 1);
        @(posedge clk);
        #3;
        arst = 1'b1;
        #1;
        chk_all("ar_async", 0, 0, 3'b000, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("ar_held", 0, 0, 3'b000, 0, 0, 0);
        arst = 1'b0;
        tick(5);
        chk_state("ar_after", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
